if_fetch_unit: RTL and testbench

Instruction fetch stage that feeds the IF/ID pipeline register. Owns the PC, issues instruction-memory read requests, and matches in-order responses to their PCs. Buffers fetched {pc, instr} pairs for the decode side, and discards wrong-path fetches after a branch/jump redirect. Drives a NOP bubble whenever it has nothing valid, so the IF/ID register can capture its outputs every cycle.

---
 rtl/if_fetch_unit_pkg.sv | 23 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 72 +++++++
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and record layouts for the instruction fetch stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // An issued read that has not come back yet, tagged with the epoch it was issued in
    typedef struct packed {
        logic        epoch;
        logic [31:0] pc;
    } inflight_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; simultaneous push and pop keep the count.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns PC and epoch, issues credit-limited imem reads,
// matches in-order responses and presents {pc, instr} or a NOP bubble to IF/ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic [31:0] pc_if_o,
    output logic [31:0] instr_if_o,
    output logic        valid_if_o
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          epoch_q, epoch_d;
    inflight_t     infl_push, infl_head;
    fetch_pkt_t    out_push, out_head;
    logic          infl_empty, out_empty;
    logic [CW-1:0] infl_cnt, out_cnt;
    logic [CW:0]   credit_used;
    logic          req_accept, rsp_take, rsp_keep, out_pop;

    always_comb begin
        out_pop          = !out_empty && !stall_i;
        // The entry leaving the output buffer this cycle returns its credit at once,
        // which is what lets a one-cycle memory stream at one instruction per cycle.
        credit_used      = {1'b0, infl_cnt} + {1'b0, out_cnt} - {{CW{1'b0}}, out_pop};
        imem_req_valid_o = !rst && (credit_used < CREDIT_MAX);
        imem_addr_o      = pc_q;
        req_accept       = imem_req_valid_o && imem_req_ready_i;

        rsp_take         = imem_rsp_valid_i && !infl_empty;
        rsp_keep         = rsp_take && (infl_head.epoch == epoch_q) && !redirect_i;

        infl_push        = '{epoch: epoch_q, pc: pc_q};
        out_push         = '{pc: infl_head.pc, instr: imem_rsp_data_i};

        pc_d             = pc_q;
        epoch_d          = epoch_q;
        if (redirect_i) begin
            pc_d    = word_align(redirect_pc_i);
            epoch_d = !epoch_q;
        end else if (req_accept) begin
            pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= word_align(RESET_PC);
            epoch_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    // Stale entries are never flushed here; they drain and are dropped on return
    fetch_fifo #(
        .WIDTH ($bits(inflight_t)),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (1'b0),
        .push_i      (req_accept),
        .push_data_i (infl_push),
        .pop_i       (rsp_take),
        .head_o      (infl_head),
        .empty_o     (infl_empty),
        .count_o     (infl_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (DEPTH)
    ) u_outbuf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i),
        .push_i      (rsp_keep),
        .push_data_i (out_push),
        .pop_i       (out_pop),
        .head_o      (out_head),
        .empty_o     (out_empty),
        .count_o     (out_cnt)
    );

    always_comb begin
        valid_if_o = !out_empty;
        pc_if_o    = ZERO_WORD;
        instr_if_o = NOP_INSTR;
        if (!out_empty) begin
            pc_if_o    = out_head.pc;
            instr_if_o = out_head.instr;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus reset, stale-drain and wrap sequences.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data;
    logic        redir, stall;
    logic [31:0] rpc, pc_if, instr_if;
    logic        valid_if;

    logic        w_req_valid, w_rsp_valid, w_valid;
    logic [31:0] w_addr, w_rsp_data, w_pc, w_instr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(req_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .redirect_i(redir), .redirect_pc_i(rpc), .stall_i(stall),
        .pc_if_o(pc_if), .instr_if_o(instr_if), .valid_if_o(valid_if)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(w_req_valid), .imem_req_ready_i(1'b1), .imem_addr_o(w_addr),
        .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(1'b0),
        .pc_if_o(w_pc), .instr_if_o(w_instr), .valid_if_o(w_valid)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] ifun(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory model: always ready, fixed latency mem_k, responses in order
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          mem_k = 1;
    int          cyc   = 0;
    logic        acc_now;
    logic [31:0] acc_addr;
    logic [31:0] out_log[$];
    logic [31:0] w_log[$];
    logic        w_pend;
    logic [31:0] w_pend_addr;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = ifun(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #1;
        acc_now  = !rst && req_valid && req_ready;
        acc_addr = req_addr;
        if (acc_now) mq.push_back('{addr: req_addr, due: cyc + mem_k});
    end

    always @(negedge clk) begin
        if (rst) begin
            w_pend      = 1'b0;
            w_rsp_valid = 1'b0;
            w_rsp_data  = 32'h0;
            w_log.delete();
        end else begin
            w_rsp_valid = w_pend;
            w_rsp_data  = ifun(w_pend_addr);
        end
        #1;
        w_pend      = !rst && w_req_valid;
        w_pend_addr = w_addr;
        if (w_pend) w_log.push_back(w_addr);
    end

    always @(negedge clk) begin
        #3;
        if (mon_en && !rst) begin
            if (valid_if) begin
                chk("instr_matches_pc", instr_if, ifun(pc_if));
                if (!stall) out_log.push_back(pc_if);
            end else begin
                chk("bubble_instr", instr_if, NOP_INSTR);
                chk("bubble_pc", pc_if, 32'h0);
            end
            if (w_valid) chk("wrap_instr_matches_pc", w_instr, ifun(w_pc));
        end
    end

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rp;
        logic        ev;
        logic [31:0] epc;
        logic        ea;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[17];

    task automatic drive(input logic st, input logic rd, input logic [31:0] rp);
        stall = st;
        redir = rd;
        rpc   = rp;
        @(negedge clk);
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst   = 1'b1;
        mem_k = k;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int bad;
        req_ready = 1'b1;
        stall     = 1'b0;
        redir     = 1'b0;
        rpc       = 32'h0;

        // st rd rpc | valid pc | accept addr  (k=1)
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h004};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b1, 32'h008};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h00C};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h010};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h014};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h018};
        vecs[12] = '{1'b0, 1'b1, 32'h203, 1'b1, 32'h014, 1'b1, 32'h01C};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h204};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h208};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h20C};

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_valid_if", valid_if, 1'b0);
        chk("rst_instr_if", instr_if, NOP_INSTR);
        chk("rst_pc_if", pc_if, 32'h0);
        chk("rst_wrap_req_valid", w_req_valid, 1'b0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 17; j++) begin
            drive(vecs[j].st, vecs[j].rd, vecs[j].rp);
            chk($sformatf("vec%0d_valid", j), valid_if, vecs[j].ev);
            chk($sformatf("vec%0d_pc", j), pc_if, vecs[j].epc);
            chk($sformatf("vec%0d_accept", j), acc_now, vecs[j].ea);
            if (vecs[j].ea) chk($sformatf("vec%0d_addr", j), acc_addr, vecs[j].eaddr);
            next_cycle();
        end

        chk("wrap_log_len", (w_log.size() >= 3) ? 1 : 0, 1);
        chk("wrap_addr0", (w_log.size() > 0) ? w_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap_addr1", (w_log.size() > 1) ? w_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_addr2", (w_log.size() > 2) ? w_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Reset mid-stream with two entries buffered
        do_reset(1);
        for (int j = 0; j < 6; j++) begin
            drive((j >= 4) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            if (j == 5) begin
                chk("midrst_pre_valid", valid_if, 1'b1);
                chk("midrst_pre_pc", pc_if, 32'h008);
                chk("midrst_pre_full_credit", req_valid, 1'b0);
            end
            next_cycle();
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0);
        chk("midrst_req_during_rst", req_valid, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        chk("midrst_valid", valid_if, 1'b0);
        chk("midrst_instr", instr_if, NOP_INSTR);
        chk("midrst_pc", pc_if, 32'h0);
        chk("midrst_req", req_valid, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("restart_acc0", acc_now, 1'b1);
        chk("restart_addr0", acc_addr, 32'h000);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        chk("restart_addr1", acc_addr, 32'h004);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        chk("restart_first_valid", valid_if, 1'b1);
        chk("restart_first_pc", pc_if, 32'h000);
        next_cycle();

        // k=3: fetch from 0x100, redirect to 0x200 with two reads in flight
        do_reset(3);
        out_log.delete();
        for (int j = 0; j < 17; j++) begin
            if (j == 0)      drive(1'b0, 1'b1, 32'h100);
            else if (j == 6) drive(1'b0, 1'b1, 32'h200);
            else             drive(1'b0, 1'b0, 32'h0);
            if (j == 5) chk("k3_first_pc", pc_if, 32'h100);
            if (j == 6) chk("k3_no_req_two_inflight", acc_now, 1'b0);
            if (j == 7) chk("k3_valid_after_redirect", valid_if, 1'b0);
            if (j == 8) begin
                chk("k3_first_new_acc", acc_now, 1'b1);
                chk("k3_first_new_addr", acc_addr, 32'h200);
            end
            if (j == 12) chk("k3_new_path_pc", pc_if, 32'h200);
            next_cycle();
        end
        bad = 0;
        foreach (out_log[i]) if (out_log[i] == 32'h104 || out_log[i] == 32'h108) bad++;
        chk("k3_stale_visible", bad, 0);
        chk("k3_log0", log_at(0), 32'h100);
        chk("k3_log1", log_at(1), 32'h200);
        chk("k3_log2", log_at(2), 32'h204);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
